int_to_float_pipe: RTL and testbench
====================================

// Module: int_to_float_pipe
// PURPOSE
//  Streaming, parametrised integer-to-float converter; successor to the 8-bit combinational converter.
//  Accepts one integer per cycle on a valid/ready input, emits {sign, exponent, fraction} 3 cycles later.
//  Adds selectable input format, round-half-even, a defined zero encoding and an inexact flag.
//  Sits between integer datapath producers and float consumers in the conversion subsystem.
// PARAMETERS
//  INT_WIDTH   16  input integer width (>= 4)
//  EXP_WIDTH   5   unbiased exponent width; must satisfy 2**EXP_WIDTH-1 >= MAG_W+1
//  FRAC_WIDTH  8   fraction width, explicit leading one at MSB (>= 2)
//  SIGNED_MODE 1   1 = two's complement input; 0 = sign-magnitude (MSB sign, rest magnitude)
// PORTS
//  clk_i       in   1                        clock
//  rst_ni      in   1                        async reset, active low
//  int_i       in   INT_WIDTH                integer operand
//  in_valid_i  in   1                        int_i valid
//  in_ready_o  out  1                        converter can accept int_i this cycle
//  float_o     out  1+EXP_WIDTH+FRAC_WIDTH   {sign, exponent, fraction}
//  inexact_o   out  1                        nonzero bits were discarded by rounding
//  out_valid_o out  1                        float_o/inexact_o valid
//  out_ready_i in   1                        consumer accepts float_o
// BEHAVIOUR
//  - Encoding: value = (-1)^sign * 0.fraction * 2^exponent; normalised fraction has MSB = 1.
//  - Magnitude width MAG_W = INT_WIDTH (two's comp) or INT_WIDTH-1 (sign-mag); -2^(INT_WIDTH-1) -> magnitude 2^(INT_WIDTH-1).
//  - exponent = (index of leading one in magnitude) + 1; fraction = magnitude left-aligned to FRAC_WIDTH.
//  - Bits below fraction LSB: round half to even (guard/sticky); inexact_o = any discarded bit nonzero.
//  - Round carry out of fraction: fraction = 100..0, exponent += 1.
//  - Zero (incl. sign-mag negative zero): float_o = all zeros, inexact_o = 0.
//  - Pipeline, each stage a register with its own valid:
//     S1 extract sign + magnitude; S2 leading-one count + normalising left shift; S3 round, pack.
//  - Latency 3 cycles from accepted input to out_valid_o with out_ready_i high; throughput 1/cycle.
//  - Elastic flow: stage k loads when empty or stage k+1 loads this cycle; in_ready_o = S1 loads.
//    in_ready_o is combinational from out_ready_i; no skid buffer.
//  - Transfer on valid & ready; while out_valid_o & !out_ready_i, float_o/inexact_o hold stable.
//  - Pipeline full with out_ready_i low: in_ready_o = 0; no loss, duplication or reordering.
//  - Reset (async assert, sync deassert expected upstream): all stage valids 0, all data regs 0,
//    so float_o = 0, inexact_o = 0, out_valid_o = 0; in_ready_o = 1 after reset.
//    Reset mid-stream discards in-flight items.
//  - in_valid_i low: no stage loaded; bubbles propagate, out_valid_o drops accordingly.
// STRUCTURE
//  - float_conv_pkg: mode constants SIGN_MAG/TWOS_COMP, mag_width() and float_width() functions,
//    shared with the existing float-to-int converter.
//  - Sub-module int_to_float_lzc: parametrised leading-zero counter (WIDTH in, count + all_zero out),
//    combinational, used in S2.
//  - Elaboration-time assertion on the EXP_WIDTH constraint.
// TESTING (defaults unless noted; float_o shown as sign_exp_frac)
//  1 int_i=0x0005 -> 0_00011_10100000, inexact 0;
//    0xFFFB -> 1_00011_10100000; 0x8000 -> 1_10000_10000000.
//  2 Rounding: 0x0183 -> 0_01001_11000010, inexact 1 (tie, odd LSB up);
//    0x0181 -> 0_01001_11000000, inexact 1 (tie, even kept);
//    0x7FFF -> 0_10000_10000000, inexact 1 (carry-out).
//  3 Zero: 0x0000 -> all zeros, inexact 0;
//    SIGNED_MODE=0 with 0x8000 -> all zeros; SIGNED_MODE=0, 0x8005 -> 1_00011_10100000.
//  4 Backpressure: stream 0x0001..0x0006 back-to-back, out_ready_i low cycles 2-7
//    -> in_ready_o low once 3 items held; outputs exponents 1,2,2,3,3,3 in order, none lost or repeated.
//  5 Throughput: 100 random inputs, out_ready_i=1 -> out_valid_o continuous from cycle 3;
//    every result matches the reference model.
//  6 Reset: rst_ni low while 2 items in flight -> out_valid_o=0, float_o=0 same cycle;
//    after release in_ready_o=1, no stale output.

Source files
------------

// File: rtl/float_conv_pkg.sv
// Shared definitions for the integer/float converters: input format codes
// and width helpers used by both conversion directions.
package float_conv_pkg;

   localparam int SIGN_MAG  = 0;
   localparam int TWOS_COMP = 1;

   // Two's complement needs one extra magnitude bit to hold -2^(W-1).
   function automatic int mag_width(input int int_width, input int signed_mode);
      if (signed_mode == TWOS_COMP) begin
         return int_width;
      end else begin
         return int_width - 1;
      end
   endfunction

   function automatic int float_width(input int exp_width, input int frac_width);
      return 1 + exp_width + frac_width;
   endfunction

endpackage

// File: rtl/int_to_float_lzc.sv
// Combinational leading-zero counter; count_o = WIDTH when the input is all zero.
module int_to_float_lzc #(
   parameter int WIDTH = 16,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [CW-1:0]    count_o,
   output logic             all_zero_o
);

   // Scan upward so the highest set bit is the last to write the count.
   always_comb begin
      count_o = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i]) begin
            count_o = CW'(WIDTH - 1 - i);
         end else begin
            count_o = count_o;
         end
      end
   end

   assign all_zero_o = ~|data_i;

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage elastic integer-to-float converter: S1 sign/magnitude,
// S2 leading-one normalise, S3 round-half-even and pack.
module int_to_float_pipe
   import float_conv_pkg::*;
#(
   parameter int INT_WIDTH   = 16,
   parameter int EXP_WIDTH   = 5,
   parameter int FRAC_WIDTH  = 8,
   parameter int SIGNED_MODE = 1
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic [INT_WIDTH-1:0]                         int_i,
   input  logic                                         in_valid_i,
   output logic                                         in_ready_o,
   output logic [float_width(EXP_WIDTH, FRAC_WIDTH)-1:0] float_o,
   output logic                                         inexact_o,
   output logic                                         out_valid_o,
   input  logic                                         out_ready_i
);

   localparam int MAG_W = mag_width(INT_WIDTH, SIGNED_MODE);
   localparam int FLT_W = float_width(EXP_WIDTH, FRAC_WIDTH);
   localparam int CNT_W = $clog2(MAG_W + 1);
   localparam int EXT_W = MAG_W + FRAC_WIDTH + 1;

   if (((2 ** EXP_WIDTH) - 1) < (MAG_W + 1)) begin : g_exp_width_chk
      $error("int_to_float_pipe: EXP_WIDTH too small for the largest exponent");
   end
   if ((INT_WIDTH < 4) || (FRAC_WIDTH < 2)) begin : g_width_chk
      $error("int_to_float_pipe: INT_WIDTH >= 4 and FRAC_WIDTH >= 2 required");
   end

   logic                  r_v1, r_v2, r_v3;
   logic                  r_s1_sign;
   logic [MAG_W-1:0]      r_s1_mag;
   logic                  r_s2_sign, r_s2_zero;
   logic [EXP_WIDTH-1:0]  r_s2_exp;
   logic [MAG_W-1:0]      r_s2_norm;
   logic [FLT_W-1:0]      r_float;
   logic                  r_inexact;

   logic                  w_ld1, w_ld2, w_ld3;
   logic [MAG_W-1:0]      w_in_mag;
   logic                  w_in_sign;
   logic [CNT_W-1:0]      w_lzc_cnt;
   logic                  w_lzc_zero;
   logic [MAG_W-1:0]      w_norm;
   logic [EXP_WIDTH-1:0]  w_exp;
   logic [EXT_W-1:0]      w_ext;
   logic [FRAC_WIDTH-1:0] w_frac_t;
   logic                  w_guard, w_sticky, w_rnd_up;
   logic [FRAC_WIDTH:0]   w_frac_sum;
   logic [EXP_WIDTH-1:0]  w_exp_out;
   logic [FRAC_WIDTH-1:0] w_frac_out;
   logic                  w_inexact;
   logic [FLT_W-1:0]      w_pack;

   // A stage may load when it is empty or its successor is loading.
   assign w_ld3      = ~r_v3 | out_ready_i;
   assign w_ld2      = ~r_v2 | w_ld3;
   assign w_ld1      = ~r_v1 | w_ld2;
   assign in_ready_o = w_ld1;

   if (SIGNED_MODE == TWOS_COMP) begin : g_twos
      logic [INT_WIDTH-1:0] w_neg;
      assign w_neg    = (~int_i) + INT_WIDTH'(1);
      assign w_in_mag = int_i[INT_WIDTH-1] ? w_neg : int_i;
   end else begin : g_smag
      assign w_in_mag = int_i[INT_WIDTH-2:0];
   end
   // Zero of either sign carries no sign so it packs to all zeros.
   assign w_in_sign = int_i[INT_WIDTH-1] & (|w_in_mag);

   // S1: capture sign and magnitude.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_v1      <= 1'b0;
         r_s1_sign <= 1'b0;
         r_s1_mag  <= '0;
      end else if (w_ld1) begin
         r_v1 <= in_valid_i;
         if (in_valid_i) begin
            r_s1_sign <= w_in_sign;
            r_s1_mag  <= w_in_mag;
         end
      end
   end

   int_to_float_lzc #(
      .WIDTH (MAG_W),
      .CW    (CNT_W)
   ) u_lzc (
      .data_i     (r_s1_mag),
      .count_o    (w_lzc_cnt),
      .all_zero_o (w_lzc_zero)
   );

   assign w_norm = r_s1_mag << w_lzc_cnt;
   assign w_exp  = EXP_WIDTH'(MAG_W) - EXP_WIDTH'(w_lzc_cnt);

   // S2: normalised magnitude and exponent.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_v2      <= 1'b0;
         r_s2_sign <= 1'b0;
         r_s2_zero <= 1'b0;
         r_s2_exp  <= '0;
         r_s2_norm <= '0;
      end else if (w_ld2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_s2_sign <= r_s1_sign;
            r_s2_zero <= w_lzc_zero;
            r_s2_exp  <= w_exp;
            r_s2_norm <= w_norm;
         end
      end
   end

   // Pad below the magnitude so guard/sticky exist even when nothing is discarded.
   assign w_ext      = {r_s2_norm, {(FRAC_WIDTH + 1){1'b0}}};
   assign w_frac_t   = w_ext[EXT_W-1 -: FRAC_WIDTH];
   assign w_guard    = w_ext[EXT_W-1-FRAC_WIDTH];
   assign w_sticky   = |w_ext[EXT_W-2-FRAC_WIDTH:0];
   assign w_rnd_up   = w_guard & (w_sticky | w_frac_t[0]);
   assign w_frac_sum = {1'b0, w_frac_t} + {{FRAC_WIDTH{1'b0}}, w_rnd_up};

   // Round-half-even with carry renormalisation; zero forced to all-zero encoding.
   always_comb begin
      w_exp_out  = r_s2_exp;
      w_frac_out = w_frac_sum[FRAC_WIDTH-1:0];
      w_inexact  = w_guard | w_sticky;
      if (r_s2_zero) begin
         w_exp_out  = '0;
         w_frac_out = '0;
         w_inexact  = 1'b0;
      end else if (w_frac_sum[FRAC_WIDTH]) begin
         w_exp_out  = r_s2_exp + EXP_WIDTH'(1);
         w_frac_out = {1'b1, {(FRAC_WIDTH - 1){1'b0}}};
      end else begin
         w_exp_out  = r_s2_exp;
      end
   end

   assign w_pack = {r_s2_sign & ~r_s2_zero, w_exp_out, w_frac_out};

   // S3: output register, held while the consumer stalls.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_v3      <= 1'b0;
         r_float   <= '0;
         r_inexact <= 1'b0;
      end else if (w_ld3) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_float   <= w_pack;
            r_inexact <= w_inexact;
         end
      end
   end

   assign float_o     = r_float;
   assign inexact_o   = r_inexact;
   assign out_valid_o = r_v3;

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Directed self-checking bench for int_to_float_pipe (two's complement and
// sign-magnitude instances at default widths).
module tb_int_to_float_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [15:0] tc_int = 16'h0000;
   logic        tc_valid = 1'b0, tc_out_ready = 1'b1;
   logic        tc_in_ready, tc_out_valid, tc_inexact;
   logic [13:0] tc_float;

   logic [15:0] sm_int = 16'h0000;
   logic        sm_valid = 1'b0, sm_out_ready = 1'b1;
   logic        sm_in_ready, sm_out_valid, sm_inexact;
   logic [13:0] sm_float;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   int_to_float_pipe #(
      .INT_WIDTH(16), .EXP_WIDTH(5), .FRAC_WIDTH(8), .SIGNED_MODE(1)
   ) dut_tc (
      .clk_i(clk), .rst_ni(rst_n), .int_i(tc_int), .in_valid_i(tc_valid),
      .in_ready_o(tc_in_ready), .float_o(tc_float), .inexact_o(tc_inexact),
      .out_valid_o(tc_out_valid), .out_ready_i(tc_out_ready)
   );

   int_to_float_pipe #(
      .INT_WIDTH(16), .EXP_WIDTH(5), .FRAC_WIDTH(8), .SIGNED_MODE(0)
   ) dut_sm (
      .clk_i(clk), .rst_ni(rst_n), .int_i(sm_int), .in_valid_i(sm_valid),
      .in_ready_o(sm_in_ready), .float_o(sm_float), .inexact_o(sm_inexact),
      .out_valid_o(sm_out_valid), .out_ready_i(sm_out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Independent reference: integer arithmetic, remainder compared with half.
   task automatic ref_conv(input logic [15:0] v, output logic [13:0] f, output logic x);
      int  mag, msb, e, sh, fr, rem, half;
      bit  s;
      s   = v[15];
      mag = s ? (65536 - int'(v)) : int'(v);
      f   = 14'h0000;
      x   = 1'b0;
      if (mag != 0) begin
         msb = 0;
         for (int i = 0; i < 17; i++) if (((mag >> i) & 1) == 1) msb = i;
         e = msb + 1;
         if (e <= 8) begin
            fr = mag << (8 - e);
         end else begin
            sh   = e - 8;
            fr   = mag >> sh;
            rem  = mag - (fr << sh);
            half = 1 << (sh - 1);
            if ((rem > half) || ((rem == half) && ((fr % 2) == 1))) fr = fr + 1;
            x = (rem != 0);
            if (fr == 256) begin
               fr = 128;
               e  = e + 1;
            end
         end
         f = {s, 5'(e), 8'(fr)};
      end
   endtask

   task automatic convert(input bit sm, input logic [15:0] v, input logic [13:0] ef,
                          input logic ei, input string tag);
      int          cyc;
      logic        ov;
      @(negedge clk);
      if (sm) begin sm_int = v; sm_valid = 1'b1; end
      else    begin tc_int = v; tc_valid = 1'b1; end
      @(negedge clk);
      sm_valid = 1'b0;
      tc_valid = 1'b0;
      cyc = 1;
      ov  = sm ? sm_out_valid : tc_out_valid;
      while (!ov && cyc < 10) begin
         @(negedge clk);
         cyc++;
         ov = sm ? sm_out_valid : tc_out_valid;
      end
      check({tag, " latency"}, 32'(cyc), 32'd3);
      check({tag, " float"}, 32'(sm ? sm_float : tc_float), 32'(ef));
      check({tag, " inexact"}, 32'(sm ? sm_inexact : tc_inexact), 32'(ei));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] bp_exp [6];
      logic [13:0] outs [$];
      logic [15:0] vals [100];
      logic [13:0] ef;
      logic        ex;
      int idx, got_n, first_c, gaps, extra, stale;

      // Reset state
      #12;
      check("reset out_valid", 32'(tc_out_valid), 32'd0);
      check("reset float", 32'(tc_float), 32'd0);
      check("reset inexact", 32'(tc_inexact), 32'd0);
      check("reset in_ready", 32'(tc_in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic conversions
      convert(1'b0, 16'h0005, {1'b0, 5'b00011, 8'b10100000}, 1'b0, "pos5");
      convert(1'b0, 16'hFFFB, {1'b1, 5'b00011, 8'b10100000}, 1'b0, "neg5");
      convert(1'b0, 16'h8000, {1'b1, 5'b10000, 8'b10000000}, 1'b0, "most_neg");
      // Rounding
      convert(1'b0, 16'h0183, {1'b0, 5'b01001, 8'b11000010}, 1'b1, "tie_odd_up");
      convert(1'b0, 16'h0181, {1'b0, 5'b01001, 8'b11000000}, 1'b1, "tie_even_keep");
      convert(1'b0, 16'h7FFF, {1'b0, 5'b10000, 8'b10000000}, 1'b1, "carry_out");
      // Zero handling
      convert(1'b0, 16'h0000, 14'h0000, 1'b0, "zero_tc");
      convert(1'b1, 16'h8000, 14'h0000, 1'b0, "neg_zero_sm");
      convert(1'b1, 16'h8005, {1'b1, 5'b00011, 8'b10100000}, 1'b0, "neg5_sm");

      // Backpressure: out_ready low cycles 2..7
      bp_exp[0] = {1'b0, 5'd1, 8'b10000000};
      bp_exp[1] = {1'b0, 5'd2, 8'b10000000};
      bp_exp[2] = {1'b0, 5'd2, 8'b11000000};
      bp_exp[3] = {1'b0, 5'd3, 8'b10000000};
      bp_exp[4] = {1'b0, 5'd3, 8'b10100000};
      bp_exp[5] = {1'b0, 5'd3, 8'b11000000};
      idx = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         tc_out_ready = !((c >= 2) && (c <= 7));
         if (idx < 6) begin tc_int = 16'(idx + 1); tc_valid = 1'b1; end
         else         begin tc_valid = 1'b0; end
         #1;
         if (c == 4) begin
            check("bp in_ready full", 32'(tc_in_ready), 32'd0);
            check("bp items held", 32'(idx), 32'd3);
         end
         if (c == 6) begin
            check("bp hold valid", 32'(tc_out_valid), 32'd1);
            check("bp hold float", 32'(tc_float), 32'(bp_exp[0]));
         end
         if (tc_out_valid && tc_out_ready) outs.push_back(tc_float);
         if (tc_valid && tc_in_ready) idx++;
      end
      tc_valid = 1'b0;
      tc_out_ready = 1'b1;
      check("bp output count", 32'(outs.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("bp out%0d", i), 32'((i < outs.size()) ? outs[i] : 14'h3FFF),
               32'(bp_exp[i]));
      end

      // Throughput with random operands
      vals[0] = 16'h0000; vals[1] = 16'h8000; vals[2] = 16'h7FFF; vals[3] = 16'hFFFF;
      for (int i = 4; i < 100; i++) vals[i] = 16'($urandom);
      got_n = 0; first_c = -1; gaps = 0; extra = 0;
      for (int c = 0; c < 110; c++) begin
         @(negedge clk);
         if (tc_out_valid) begin
            if (first_c < 0) first_c = c;
            if (got_n < 100) begin
               ref_conv(vals[got_n], ef, ex);
               check($sformatf("rand%0d float", got_n), 32'(tc_float), 32'(ef));
               check($sformatf("rand%0d inexact", got_n), 32'(tc_inexact), 32'(ex));
               got_n++;
            end else begin
               extra++;
            end
         end else if ((first_c >= 0) && (got_n < 100)) begin
            gaps++;
         end
         if (c < 100) begin tc_int = vals[c]; tc_valid = 1'b1; end
         else         begin tc_valid = 1'b0; end
      end
      check("tp first output cycle", 32'(first_c), 32'd3);
      check("tp gaps", 32'(gaps), 32'd0);
      check("tp count", 32'(got_n), 32'd100);
      check("tp extra", 32'(extra), 32'd0);

      // Reset with two items in flight (one already at the output)
      @(negedge clk);
      tc_out_ready = 1'b0;
      tc_int = 16'h0011; tc_valid = 1'b1;
      @(negedge clk);
      tc_int = 16'h0022;
      @(negedge clk);
      tc_valid = 1'b0;
      @(negedge clk);
      check("rst pre out_valid", 32'(tc_out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(tc_out_valid), 32'd0);
      check("rst float", 32'(tc_float), 32'd0);
      check("rst inexact", 32'(tc_inexact), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tc_out_ready = 1'b1;
      #1;
      check("rst in_ready", 32'(tc_in_ready), 32'd1);
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (tc_out_valid) stale++;
      end
      check("rst stale outputs", 32'(stale), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
